// File: rtl/month_counter_pkg.sv
// Shared constants, FSM encoding and month-advance helper for the calendar month stage.
package month_counter_pkg;

    localparam int MONTH_W = 6;
    localparam int YEAR_W  = 7;

    localparam logic [MONTH_W-1:0] MONTH_MIN = 6'd1;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 6'd12;
    localparam logic [MONTH_W-1:0] MONTH_FEB = 6'd2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_EDIT = 1'b1
    } state_t;

    // Any value outside 1..11 (including 12 and forced garbage) lands on MONTH_MIN.
    function automatic logic [MONTH_W-1:0] next_month(input logic [MONTH_W-1:0] m);
        if (m >= MONTH_MIN && m < MONTH_MAX)
            return m + MONTH_MIN;
        else
            return MONTH_MIN;
    endfunction

endpackage

// File: rtl/month_counter_if.sv
// Bus between the month stage and its neighbours (mode controls, day carry, year, outputs).
interface month_counter_if;
    import month_counter_pkg::*;

    logic               display;
    logic               setup_month;
    logic               inc;
    logic               done_day;
    logic [YEAR_W-1:0]  curr_year;
    logic [MONTH_W-1:0] month;
    logic [MONTH_W-1:0] days_in_month;
    logic               done_month;

    modport master (
        output display, setup_month, inc, done_day, curr_year,
        input  month, days_in_month, done_month
    );

    modport slave (
        input  display, setup_month, inc, done_day, curr_year,
        output month, days_in_month, done_month
    );

endinterface

// File: rtl/month_counter_len.sv
// Combinational month length lookup; also used by the day stage for its wrap limit.
module month_len
    import month_counter_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  curr_year,
    output logic [MONTH_W-1:0] days_in_month
);

    logic leap;
    logic unused_year_hi;

    // Century is 2000-2099, so divisibility by 4 alone decides leap years.
    assign leap           = (curr_year[1:0] == 2'b00);
    assign unused_year_hi = ^curr_year[YEAR_W-1:2];

    always_comb begin
        days_in_month = 6'd31;
        case (month)
            6'd1, 6'd3, 6'd5, 6'd7, 6'd8, 6'd10, 6'd12: days_in_month = 6'd31;
            6'd4, 6'd6, 6'd9, 6'd11:                    days_in_month = 6'd30;
            MONTH_FEB:                                  days_in_month = leap ? 6'd29 : 6'd28;
            default:                                    days_in_month = 6'd31;
        endcase
    end

endmodule

// File: rtl/month_counter.sv
// Month stage of the calendar clock: counts day carries in run mode, button edits in setup mode.
module month_counter
    import month_counter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    month_counter_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic               inc_q;
    logic               adv;
    logic               carry;
    logic               done_q;
    logic [MONTH_W-1:0] month_q;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (!bus.display) state_nxt = S_EDIT;
            S_EDIT:  if (bus.display)  state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // The current state decides what counts, so a carry coinciding with display falling still advances.
    always_comb begin
        adv   = 1'b0;
        carry = 1'b0;
        case (state)
            S_RUN: begin
                adv   = bus.done_day;
                carry = bus.done_day && (month_q == MONTH_MAX);
            end
            S_EDIT: begin
                adv   = bus.setup_month && bus.inc && !inc_q;
            end
            default: begin
                adv   = 1'b0;
                carry = 1'b0;
            end
        endcase
    end

    // inc_q tracks inc every cycle so a button held across edit entry never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            month_q <= MONTH_MIN;
            done_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            inc_q  <= bus.inc;
            done_q <= carry;
            if (adv)
                month_q <= next_month(month_q);
        end
    end

    assign bus.month      = month_q;
    assign bus.done_month = done_q;

    month_len u_len (
        .month         (month_q),
        .curr_year     (bus.curr_year),
        .days_in_month (bus.days_in_month)
    );

endmodule

// File: tb/tb_month_counter.sv
// Directed bench for month_counter: run counting, leap lookup, setup edits, mode/reset corner cases.
module tb_month_counter;
    import month_counter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   em;

    logic [5:0] dim_ny [1:12] = '{6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
                                  6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31};

    always #5 clk = ~clk;

    month_counter_if bus ();

    month_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.display     = 1'b1;
        bus.setup_month = 1'b0;
        bus.inc         = 1'b0;
        bus.done_day    = 1'b0;
        bus.curr_year   = 7'd1;
        tick();
        rst = 1'b0;
        tick();
        check("reset_month", bus.month, 1);
        check("reset_done", bus.done_month, 0);
        check("reset_dim", bus.days_in_month, 31);

        // Twelve day carries in run mode, 5 cycles apart.
        em = 1;
        for (int k = 1; k <= 12; k++) begin
            bus.done_day = 1'b1;
            tick();
            bus.done_day = 1'b0;
            em = (em == 12) ? 1 : em + 1;
            check("run_month", bus.month, em);
            check("run_done", bus.done_month, (k == 12) ? 1 : 0);
            check("run_dim", bus.days_in_month, dim_ny[em]);
            tick();
            check("run_done_clr", bus.done_month, 0);
            tick(3);
        end

        bus.done_day = 1'b1;
        tick();
        bus.done_day = 1'b0;
        check("feb_month", bus.month, 2);
        bus.curr_year = 7'd32;
        #1 check("feb_y32", bus.days_in_month, 29);
        bus.curr_year = 7'd33;
        #1 check("feb_y33", bus.days_in_month, 28);
        bus.curr_year = 7'd0;
        #1 check("feb_y00", bus.days_in_month, 29);
        bus.curr_year = 7'd1;

        // Carry and display falling on the same edge: still counted.
        bus.display  = 1'b0;
        bus.done_day = 1'b1;
        tick();
        bus.done_day = 1'b0;
        check("race_month", bus.month, 3);

        bus.setup_month = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.inc = 1'b1;
            tick();
            bus.inc = 1'b0;
            tick();
        end
        check("edit_to_11", bus.month, 11);

        bus.inc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("held_inc", bus.month, 12);
        end
        bus.inc = 1'b0;
        tick();
        em = 12;
        for (int k = 0; k < 3; k++) begin
            bus.inc = 1'b1;
            tick();
            bus.inc = 1'b0;
            em = (em == 12) ? 1 : em + 1;
            check("pulse_month", bus.month, em);
            check("pulse_done", bus.done_month, 0);
            tick();
            check("pulse_done2", bus.done_month, 0);
        end

        bus.setup_month = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.done_day = 1'b1;
            tick();
            bus.done_day = 1'b0;
            tick();
        end
        check("edit_ignore_day", bus.month, 3);
        bus.inc = 1'b1;
        tick();
        bus.inc = 1'b0;
        tick();
        check("edit_ignore_inc", bus.month, 3);

        bus.display = 1'b1;
        tick();
        bus.done_day = 1'b1;
        tick();
        bus.done_day = 1'b0;
        check("back_to_run", bus.month, 4);
        check("back_done", bus.done_month, 0);

        // inc held through edit entry must not count.
        bus.inc = 1'b1;
        tick(2);
        bus.display     = 1'b0;
        bus.setup_month = 1'b1;
        tick(3);
        check("held_entry", bus.month, 4);
        bus.inc = 1'b0;
        tick();
        bus.inc = 1'b1;
        tick();
        check("fresh_edge", bus.month, 5);
        bus.inc = 1'b0;
        tick();

        rst     = 1'b1;
        bus.inc = 1'b1;
        tick();
        rst     = 1'b0;
        bus.inc = 1'b0;
        check("rst_edit_month", bus.month, 1);
        check("rst_edit_done", bus.done_month, 0);
        check("rst_edit_dim", bus.days_in_month, 31);

        bus.display     = 1'b1;
        bus.setup_month = 1'b0;
        tick();
        for (int k = 0; k < 11; k++) begin
            bus.done_day = 1'b1;
            tick();
            bus.done_day = 1'b0;
            tick();
        end
        check("pre_wrap_month", bus.month, 12);
        check("pre_wrap_dim", bus.days_in_month, 31);

        rst          = 1'b1;
        bus.done_day = 1'b1;
        tick();
        rst          = 1'b0;
        bus.done_day = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rst_wrap_month", bus.month, 1);
            check("rst_wrap_done", bus.done_month, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/month_counter.md
MONTH_COUNTER -- requirements
Module: month_counter

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, system clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have these ports: display, input, 1 bit, mode select; 1 = run/display mode, 0 = setup mode.
REQ-004 The block SHALL have these ports: setup_month, input, 1 bit, selects the month field for editing while in setup mode.
REQ-005 The block SHALL have these ports: inc, input, 1 bit, level increment button, already synchronized upstream.
REQ-006 The block SHALL have these ports: done_day, input, 1 bit, one-cycle carry pulse from the day stage on day wrap.
REQ-007 The block SHALL have these ports: curr_year, input, 7 bits, year within century, 0..99.
REQ-008 The block SHALL have these ports: month, output, 6 bits, current month, 1..12; feeds the day stage's curr_month.
REQ-009 The block SHALL have these ports: days_in_month, output, 6 bits, length of the current month, 28..31.
REQ-010 The block SHALL have these ports: done_month, output, 1 bit, one-cycle carry pulse to the year stage.

Function
REQ-011 The block SHALL implement a 2-state FSM with states S_RUN and S_EDIT.
REQ-012 The FSM SHALL transition S_RUN->S_EDIT on a clock edge with display=0, and S_EDIT->S_RUN on a clock edge with display=1.
REQ-013 In S_RUN, a done_day pulse SHALL advance month by 1 on the same edge: 1..11 -> +1, and 12 -> 1.
REQ-014 In S_RUN, done_month SHALL be asserted for exactly the one cycle after the edge at which month goes 12->1 (registered, latency 1 from done_day), and 0 otherwise.
REQ-015 In S_EDIT, done_day SHALL be ignored and month SHALL not change due to it.
REQ-016 In S_EDIT with setup_month=1, a rising edge of inc SHALL advance month by 1 with 12->1 wrap and SHALL NOT assert done_month.
REQ-017 Rising-edge detection of inc SHALL use one internal register of inc's previous value, so that a held inc produces exactly one increment.
REQ-018 In S_EDIT with setup_month=0, inc SHALL be ignored.
REQ-019 The inc edge register SHALL update every cycle regardless of state, so that an inc held across S_RUN->S_EDIT entry does not fire.
REQ-020 days_in_month SHALL be combinational from month and curr_year: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 when curr_year[1:0]==0 (the century is 2000-2099, so year 00 is a leap year); 28 for month 2 otherwise.
REQ-021 A month value outside 1..12 SHALL NOT be reachable; if one is forced, the next update SHALL load 1 and days_in_month SHALL read 31.
REQ-022 A simultaneous done_day and display falling edge SHALL be resolved by the current state: done_day counts if the FSM is still in S_RUN on that edge.
REQ-023 Arithmetic SHALL be 6-bit unsigned, with no overflow beyond 12.

Reset
REQ-024 rst=1 at a clock edge SHALL set month=1, done_month=0, the FSM to S_RUN, and the inc edge register to 0.
REQ-025 rst SHALL take priority over all other inputs, including mid-edit and coincident done_day.
REQ-026 rst asserted in the same cycle as a pending 12->1 wrap SHALL suppress done_month.
REQ-027 After rst, days_in_month SHALL read 31.

Structure
REQ-028 The shared clock package SHALL hold: MONTH_MIN=1, MONTH_MAX=12, MONTH_FEB=2, field width constants (MONTH_W=6, YEAR_W=7), and the FSM state encoding.
REQ-029 The design SHALL contain one combinational sub-module, month_len, mapping (month, curr_year) to days_in_month; the day stage SHALL reuse month_len for its wrap limit.
REQ-030 All sequential logic SHALL reside in month_counter, in a single clock domain with no latches.

Verification
REQ-031 Scenario: rst for 1 cycle, then idle -> month=1, done_month=0, days_in_month=31.
REQ-032 Scenario: display=1, 12 done_day pulses spaced 5 cycles apart from month=1 -> month steps 2..12, then 1; done_month high exactly once, one cycle after the 12->1 edge.
REQ-033 Scenario: curr_year=32, month=2 -> days_in_month=29; curr_year=33 -> days_in_month=28; curr_year=0 -> days_in_month=29.
REQ-034 Scenario: display=0, setup_month=1, inc held high for 10 cycles, then three 1-cycle pulses from month=11 -> month=12, then 1, 2, 3; done_month stays 0.
REQ-035 Scenario: display=0, done_day pulsed 4 times -> month unchanged; then display=1 and one done_day -> month+1.
REQ-036 Scenario: month=12, done_day and rst asserted on the same edge -> month=1, done_month=0 on all following cycles.
